vout_sinepwm3_ctrl: RTL and testbench



---
 rtl/vout_sinepwm_pkg.sv | 31 +++
 rtl/vout_sine_rom.sv | 56 +++++
 rtl/vout_sinepwm3_ctrl.sv | 134 +++++++++++++
 tb/tb_vout_sinepwm3_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vout_sinepwm_pkg.sv
// Shared types, table geometry and the amplitude-scaling helper for the
// three-phase sine-PWM sequencer.
package vout_sinepwm_pkg;

    localparam int unsigned TBL_DEPTH   = 30;
    localparam int unsigned PHASE_OFS_B = 10;
    localparam int unsigned PHASE_OFS_C = 20;
    localparam int unsigned MIDPOINT    = 128;

    typedef logic [7:0] duty_t;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, DONE} state_e;

    function automatic logic [4:0] phase_addr(input logic [4:0] base, input int unsigned ofs);
        logic [5:0] sum;
        sum = 6'(base) + 6'(ofs);
        return (sum >= 6'(TBL_DEPTH)) ? 5'(sum - 6'(TBL_DEPTH)) : 5'(sum);
    endfunction

    // Signed offset from midpoint times unsigned amp; >>> floors toward -inf.
    function automatic duty_t scale_sample(input duty_t s, input logic [7:0] amp);
        logic signed [8:0]  diff;
        logic signed [17:0] prod;
        logic signed [17:0] shifted;
        diff    = $signed({1'b0, s}) - 9'sd128;
        prod    = 18'(diff) * $signed({10'b0, amp});
        shifted = prod >>> 8;
        return duty_t'(shifted + 18'(MIDPOINT));
    endfunction

endpackage

// File: rtl/vout_sine_rom.sv
// 30-entry, 8-bit sine table with a one-cycle synchronous read.
module vout_sine_rom
    import vout_sinepwm_pkg::*;
(
    input  logic       clk,
    input  logic [4:0] addr_i,
    output duty_t      data_o
);

    duty_t data_q;
    duty_t data_d;

    always_comb begin
        data_d = duty_t'(MIDPOINT);
        case (addr_i)
            5'd0:  data_d = 8'd128;
            5'd1:  data_d = 8'd153;
            5'd2:  data_d = 8'd177;
            5'd3:  data_d = 8'd199;
            5'd4:  data_d = 8'd217;
            5'd5:  data_d = 8'd232;
            5'd6:  data_d = 8'd242;
            5'd7:  data_d = 8'd247;
            5'd8:  data_d = 8'd247;
            5'd9:  data_d = 8'd242;
            5'd10: data_d = 8'd232;
            5'd11: data_d = 8'd217;
            5'd12: data_d = 8'd199;
            5'd13: data_d = 8'd177;
            5'd14: data_d = 8'd153;
            5'd15: data_d = 8'd128;
            5'd16: data_d = 8'd103;
            5'd17: data_d = 8'd79;
            5'd18: data_d = 8'd57;
            5'd19: data_d = 8'd39;
            5'd20: data_d = 8'd24;
            5'd21: data_d = 8'd14;
            5'd22: data_d = 8'd9;
            5'd23: data_d = 8'd9;
            5'd24: data_d = 8'd14;
            5'd25: data_d = 8'd24;
            5'd26: data_d = 8'd39;
            5'd27: data_d = 8'd57;
            5'd28: data_d = 8'd79;
            5'd29: data_d = 8'd103;
            default: data_d = duty_t'(MIDPOINT);
        endcase
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/vout_sinepwm3_ctrl.sv
// Three-phase sine-PWM sequencer: step timer, shared sine index, ROM-sharing
// scheduler, shadow duty set committed at carrier wrap, registered PWM pins.
module vout_sinepwm3_ctrl
    import vout_sinepwm_pkg::*;
#(
    parameter int unsigned START   = 0,
    parameter int unsigned DIVIDER = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] freq,
    input  logic [7:0]  amp,
    output logic [2:0]  pwm_out,
    output logic [4:0]  phase_idx,
    output logic        busy,
    output logic        step_overrun
);

    localparam logic [7:0] CAR_MAX = 8'(DIVIDER - 1);

    logic [31:0] freq_abs;
    logic        run;
    logic        tick;
    logic        req;
    logic        wrap;
    logic [31:0] timer_q, timer_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  carrier_q, carrier_d;
    logic [2:0]  pwm_q, pwm_d;
    logic [4:0]  base_q;
    logic [4:0]  rom_addr;
    duty_t       rom_data;
    duty_t       scaled;
    duty_t [2:0] hold_q;
    duty_t [2:0] shadow_q;
    duty_t [2:0] active_q;
    logic        valid_q;
    logic        pending_q;
    logic        overrun_q;
    state_e      state_q;

    vout_sine_rom u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    assign scaled = scale_sample(rom_data, amp);

    always_comb begin
        freq_abs = freq[31] ? (~freq + 32'd1) : freq;
        run      = enable && (freq != '0);
        tick     = run && (timer_q >= freq_abs - 32'd1);
        timer_d  = (run && !tick) ? timer_q + 32'd1 : '0;
        idx_d    = idx_q;
        if (tick) begin
            if (freq[31])
                idx_d = (idx_q == '0) ? 5'(TBL_DEPTH - 1) : idx_q - 5'd1;
            else
                idx_d = (idx_q == 5'(TBL_DEPTH - 1)) ? '0 : idx_q + 5'd1;
        end
        req       = tick || pending_q;
        wrap      = (carrier_q == CAR_MAX);
        carrier_d = wrap ? '0 : carrier_q + 8'd1;
        for (int unsigned i = 0; i < 3; i++)
            pwm_d[i] = run && (carrier_q < active_q[i]);
        // Address is registered by the ROM one state ahead of its capture.
        case (state_q)
            IDLE:    rom_addr = idx_d;
            RD_A:    rom_addr = phase_addr(base_q, PHASE_OFS_B);
            RD_B:    rom_addr = phase_addr(base_q, PHASE_OFS_C);
            default: rom_addr = base_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            idx_q     <= 5'(START);
            carrier_q <= '0;
            pwm_q     <= '0;
            active_q  <= '0;
        end else begin
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            carrier_q <= carrier_d;
            pwm_q     <= pwm_d;
            if (wrap && valid_q)
                active_q <= shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            hold_q    <= '0;
            shadow_q  <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    state_q   <= RD_A;
                    base_q    <= idx_d;
                    pending_q <= 1'b0;
                end
                RD_A: begin hold_q[0] <= scaled; state_q <= RD_B; end
                RD_B: begin hold_q[1] <= scaled; state_q <= RD_C; end
                RD_C: begin hold_q[2] <= scaled; state_q <= DONE; end
                default: state_q <= IDLE;
            endcase
            if (tick && state_q != IDLE) begin
                if (pending_q) overrun_q <= 1'b1;
                else           pending_q <= 1'b1;
            end
            // A fresh shadow written on the wrap edge survives for the next wrap.
            if (state_q == DONE) begin
                shadow_q <= hold_q;
                valid_q  <= 1'b1;
            end else if (wrap && valid_q) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign phase_idx    = idx_q;
    assign busy         = (state_q != IDLE);
    assign step_overrun = overrun_q;

endmodule

// File: tb/tb_vout_sinepwm3_ctrl.sv
// Self-checking bench: hand-derived vectors, corner sequences and randomized
// traffic against a cycle-level reference of the sequencer.
module tb_vout_sinepwm3_ctrl;

    localparam int unsigned START  = 27;
    localparam int unsigned DIV    = 100;
    localparam logic [31:0] FREEZE = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] freq = '0;
    logic [7:0]  amp = '0;
    logic [2:0]  pwm_out;
    logic [4:0]  phase_idx;
    logic        busy;
    logic        step_overrun;

    int n_chk = 0;
    int n_err = 0;

    vout_sinepwm3_ctrl #(.START(START), .DIVIDER(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .freq         (freq),
        .amp          (amp),
        .pwm_out      (pwm_out),
        .phase_idx    (phase_idx),
        .busy         (busy),
        .step_overrun (step_overrun)
    );

    always #5 clk = ~clk;

    // Reference state
    longint unsigned m_timer;
    int m_idx, m_left, m_base, m_car;
    bit m_pend, m_ovr, m_valid;
    int m_sh[3];
    int m_act[3];
    logic [2:0] m_pwm;

    function automatic int sine_at(int i);
        real x;
        x = 128.0 + 120.0 * $sin(2.0 * 3.14159265358979 * i / 30.0);
        return int'($floor(x + 0.5));
    endfunction

    function automatic int scale(int s, int a);
        int p;
        p = (s - 128) * a;
        if (p >= 0) return 128 + p / 256;
        return 128 - ((-p + 255) / 256);
    endfunction

    task automatic model_step();
        longint unsigned fa;
        bit run, tick, done;
        int nidx;
        logic [2:0] nxt;
        if (rst) begin
            m_timer = 0; m_idx = START; m_left = 0; m_base = 0; m_car = 0;
            m_pend = 0; m_ovr = 0; m_valid = 0; m_pwm = '0;
            for (int i = 0; i < 3; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            return;
        end
        fa   = freq[31] ? (64'h1_0000_0000 - {32'b0, freq}) : {32'b0, freq};
        run  = enable && (fa != 0);
        tick = run && (m_timer >= fa - 1);
        for (int i = 0; i < 3; i++) nxt[i] = run && (m_car < m_act[i]);
        if (m_car == DIV - 1 && m_valid) begin
            for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
            m_valid = 0;
        end
        done = (m_left == 1);
        if (done) begin
            for (int i = 0; i < 3; i++)
                m_sh[i] = scale(sine_at((m_base + 10 * i) % 30), int'(amp));
            m_valid = 1;
        end
        nidx = m_idx;
        if (tick) nidx = freq[31] ? (m_idx + 29) % 30 : (m_idx + 1) % 30;
        if (m_left == 0) begin
            if (tick || m_pend) begin m_left = 4; m_base = nidx; m_pend = 0; end
        end else begin
            m_left--;
            if (tick) begin
                if (m_pend) m_ovr = 1; else m_pend = 1;
            end
        end
        m_idx   = nidx;
        m_timer = (run && !tick) ? m_timer + 1 : 0;
        m_car   = (m_car + 1) % DIV;
        m_pwm   = nxt;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", {22'b0, pwm_out, phase_idx, busy, step_overrun},
              {22'b0, m_pwm, 5'(m_idx), m_left != 0, m_ovr});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_idx", 32'(phase_idx), 32'(START));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(step_overrun), 32'd0);
        rst = 1'b0;
    endtask

    task automatic count_period(output int ca, output int cb, output int cc);
        ca = 0; cb = 0; cc = 0;
        for (int k = 0; k < DIV; k++) begin
            cycle();
            ca += int'(pwm_out[0]);
            cb += int'(pwm_out[1]);
            cc += int'(pwm_out[2]);
        end
    endtask

    typedef struct {
        logic [31:0] freq;
        logic [7:0]  amp;
        int          run_cycles;
        logic [4:0]  idx;
        logic        ovr;
        int          hi_a, hi_b, hi_c;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ca, cb, cc;
        vecs[0] = '{32'd100,        8'd255, 100, 5'd28, 1'b0, 79,  100, 57};
        vecs[1] = '{32'd10,         8'd128, 40,  5'd1,  1'b0, 100, 100, 71};
        vecs[2] = '{32'hFFFF_FFCE,  8'd200, 100, 5'd25, 1'b0, 46,  100, 100};
        vecs[3] = '{32'hFFFF_FFFF,  8'd0,   7,   5'd20, 1'b1, 100, 100, 100};
        vecs[4] = '{32'h8000_0000,  8'd255, 300, 5'd27, 1'b0, 0,   0,   0};
        vecs[5] = '{32'd100,        8'd255, 300, 5'd0,  1'b0, 100, 100, 24};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            enable = 1'b1;
            freq   = vecs[v].freq;
            amp    = vecs[v].amp;
            repeat (vecs[v].run_cycles) cycle();
            freq = FREEZE;
            repeat (2 * DIV + 10) cycle();
            check("vec_idx", 32'(phase_idx), 32'(vecs[v].idx));
            check("vec_ovr", 32'(step_overrun), 32'(vecs[v].ovr));
            count_period(ca, cb, cc);
            check("vec_hi_a", 32'(ca), 32'(vecs[v].hi_a));
            check("vec_hi_b", 32'(cb), 32'(vecs[v].hi_b));
            check("vec_hi_c", 32'(cc), 32'(vecs[v].hi_c));
        end

        // DONE lands on the carrier-wrap cycle: commit waits a full period.
        do_reset();
        enable = 1'b1; amp = 8'd255; freq = 32'd96;
        repeat (96) cycle();
        freq = FREEZE;
        repeat (4) cycle();
        count_period(ca, cb, cc);
        check("wrap_p1_a", 32'(ca), 32'd0);
        check("wrap_p1_b", 32'(cb), 32'd0);
        check("wrap_p1_c", 32'(cc), 32'd0);
        count_period(ca, cb, cc);
        check("wrap_p2_a", 32'(ca), 32'd79);
        check("wrap_p2_b", 32'(cb), 32'd100);
        check("wrap_p2_c", 32'(cc), 32'd57);

        // Disable mid-period, then resume with retained duties.
        repeat (37) cycle();
        enable = 1'b0;
        cycle();
        check("dis_off", 32'(pwm_out), 32'd0);
        repeat (20) cycle();
        enable = 1'b1;
        count_period(ca, cb, cc);
        check("reen_a", 32'(ca), 32'd79);
        check("reen_b", 32'(cb), 32'd100);
        check("reen_c", 32'(cc), 32'd57);

        // Reset while the scheduler sits in RD_B.
        freq = '0;
        cycle();
        freq = 32'd10;
        repeat (11) cycle();
        check("rdb_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        check("rdb_rst_pwm", 32'(pwm_out), 32'd0);
        check("rdb_rst_busy", 32'(busy), 32'd0);
        check("rdb_rst_idx", 32'(phase_idx), 32'(START));
        rst = 1'b0;

        // Continuous fast stepping drops ticks; overrun is sticky.
        do_reset();
        enable = 1'b1; amp = 8'd100; freq = 32'd2;
        repeat (200) cycle();
        check("ovr_set", 32'(step_overrun), 32'd1);
        check("ovr_idx", 32'(phase_idx), 32'd7);
        freq = FREEZE;
        repeat (60) cycle();
        check("ovr_sticky", 32'(step_overrun), 32'd1);
        check("ovr_idle", 32'(busy), 32'd0);

        // Randomized segments against the reference.
        for (int seg = 0; seg < 10; seg++) begin
            int unsigned mag;
            do_reset();
            case ($urandom_range(0, 3))
                0:       mag = $urandom_range(1, 6);
                1:       mag = $urandom_range(20, 150);
                2:       mag = 0;
                default: mag = $urandom_range(5, 19);
            endcase
            freq   = $urandom_range(0, 1) ? 32'(-int'(mag)) : mag;
            amp    = 8'($urandom_range(0, 255));
            enable = 1'b1;
            for (int k = 0; k < 500; k++) begin
                if ($urandom_range(0, 59) == 0) enable = ~enable;
                rst = ($urandom_range(0, 399) == 0);
                cycle();
            end
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
